// File: rtl/ir_pkg.sv
// Shared types and defaults for the instruction-register prefetch queue.
package ir_pkg;

  localparam int IR_WIDTH_DEF = 16;
  localparam int IR_DEPTH_DEF = 4;

  typedef logic [IR_WIDTH_DEF-1:0] ir_word_t;

  localparam ir_word_t IR_RST_WORD = '0;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int ir_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ir_queue_if.sv
// Fetch/execute-side bus of the instruction queue; ovf only exists with IRQ_OVF_FLAG_EN.
interface ir_queue_if
  import ir_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH_DEF,
  parameter int DEPTH = IR_DEPTH_DEF
);

  logic                        ld;
  logic [WIDTH-1:0]            D_in;
  logic                        pop;
  logic                        flush;
  logic [WIDTH-1:0]            D_out;
  logic                        valid;
  logic                        full;
  logic [ir_cnt_w(DEPTH)-1:0]  count;
`ifdef IRQ_OVF_FLAG_EN
  logic                        ovf;
`endif

  modport master (
    output ld, D_in, pop, flush,
`ifdef IRQ_OVF_FLAG_EN
    input  ovf,
`endif
    input  D_out, valid, full, count
  );

  modport slave (
    input  ld, D_in, pop, flush,
`ifdef IRQ_OVF_FLAG_EN
    output ovf,
`endif
    output D_out, valid, full, count
  );

endinterface

// File: rtl/ir_ptr.sv
// Wrap-around queue pointer with synchronous clear and increment.
module ir_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  // DEPTH is a power of two, so natural overflow gives the modulo wrap.
  always_comb begin
    ptr_next = ptr_reg;
    if (clr) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/ir_queue.sv
// Instruction register with DEPTH-entry prefetch queue, flush and occupancy.
// Optional sticky overflow flag on the ovf port when IRQ_OVF_FLAG_EN is defined.
module ir_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH_DEF,
  parameter int DEPTH = IR_DEPTH_DEF
) (
  input logic        clk,
  input logic        rst,
  ir_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = ir_cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  logic [WIDTH-1:0] dout_reg, dout_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             valid_reg, valid_next;
  logic             full_reg, full_next;

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr_plus1;

  logic             pop_eff;
  logic             push_acc;
  logic             push_drop;

  always_comb begin
    pop_eff   = bus.pop && valid_reg;
    push_acc  = bus.ld && (!full_reg || pop_eff) && !bus.flush;
    push_drop = bus.ld && full_reg && !pop_eff;
  end

  assign rd_ptr_plus1 = rd_ptr + PW'(1);

  ir_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_eff && !bus.flush),
    .clr (bus.flush),
    .ptr (rd_ptr)
  );

  ir_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_acc),
    .clr (bus.flush),
    .ptr (wr_ptr)
  );

  // Storage carries no reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_reg[wr_ptr] <= bus.D_in;
    end
  end

  always_comb begin
    count_next = count_reg;
    dout_next  = dout_reg;
    if (bus.flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CW'(push_acc) - CW'(pop_eff);
      // The head changes when a word lands in an empty slot at the front
      // (empty queue, or the only entry popped in the same cycle), or when
      // a pop exposes an already-stored successor.
      if (push_acc && (count_reg == '0 || (pop_eff && count_reg == CW'(1)))) begin
        dout_next = bus.D_in;
      end else if (pop_eff && count_reg > CW'(1)) begin
        dout_next = mem_reg[rd_ptr_plus1];
      end
    end
    valid_next = (count_next != '0);
    full_next  = (count_next == CNT_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg  <= WIDTH'(IR_RST_WORD);
      count_reg <= '0;
      valid_reg <= 1'b0;
      full_reg  <= 1'b0;
    end else begin
      dout_reg  <= dout_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      full_reg  <= full_next;
    end
  end

  assign bus.D_out = dout_reg;
  assign bus.count = count_reg;
  assign bus.valid = valid_reg;
  assign bus.full  = full_reg;

`ifdef IRQ_OVF_FLAG_EN
  logic ovf_reg, ovf_next;

  // Flush wins over a simultaneous dropped push.
  always_comb begin
    ovf_next = ovf_reg;
    if (bus.flush) begin
      ovf_next = 1'b0;
    end else if (push_drop) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign bus.ovf = ovf_reg;
`else
  logic unused_drop;
  assign unused_drop = push_drop;
`endif

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: directed scenarios then randomized traffic
// against a queue-level reference model.
module tb_ir_queue;
  import ir_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             full;
    logic [CW-1:0]    count;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ir_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain FIFO of words plus the last shown head.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  exp_t             exp_q[$];
  exp_t             mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ld, input logic [WIDTH-1:0] din,
                      input logic pop, input logic flush);
    exp_t e;
    bit   pe;
    bit   is_full;
    @(negedge clk);
    bus.ld    = ld;
    bus.D_in  = din;
    bus.pop   = pop;
    bus.flush = flush;
    pe      = pop && (m_q.size() > 0);
    is_full = (m_q.size() == DEPTH);
    if (flush) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (ld && is_full && !pe) m_ovf = 1'b1;
      if (pe) void'(m_q.pop_front());
      if (ld && (!is_full || pe)) m_q.push_back(din);
      if (m_q.size() > 0) m_dout = m_q[0];
    end
    e.dout  = m_dout;
    e.valid = (m_q.size() > 0);
    e.full  = (m_q.size() == DEPTH);
    e.count = CW'(m_q.size());
    e.ovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    step(1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic popq();
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Asserts rst away from any clock edge and checks the outputs react at once.
  task automatic do_reset();
    @(negedge clk);
    bus.ld = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.D_in = '0;
    #2;
    rst = 1'b1;
    m_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_valid", 32'(bus.valid), 32'(0));
    chk("rst_full",  32'(bus.full),  32'(0));
    chk("rst_dout",  32'(bus.D_out), 32'(0));
`ifdef IRQ_OVF_FLAG_EN
    chk("rst_ovf",   32'(bus.ovf),   32'(0));
`endif
    $display("txn reset: count=%0d valid=%0d D_out=%h", bus.count, bus.valid, bus.D_out);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dout",  32'(bus.D_out), 32'(mon_e.dout));
      chk("valid", 32'(bus.valid), 32'(mon_e.valid));
      chk("full",  32'(bus.full),  32'(mon_e.full));
      chk("count", 32'(bus.count), 32'(mon_e.count));
`ifdef IRQ_OVF_FLAG_EN
      chk("ovf",   32'(bus.ovf),   32'(mon_e.ovf));
`endif
      $display("txn ld=%0d din=%h pop=%0d flush=%0d -> D_out=%h valid=%0d full=%0d count=%0d",
               bus.ld, bus.D_in, bus.pop, bus.flush, bus.D_out, bus.valid, bus.full, bus.count);
    end
  end

  initial begin
    bus.ld = 1'b0; bus.D_in = '0; bus.pop = 1'b0; bus.flush = 1'b0;
    m_dout = '0;
    m_ovf  = 1'b0;
    do_reset();
    idle(2);

    // Three pushes, head held, then drain.
    push(16'h1111); push(16'h2222); push(16'h3333);
    popq(); popq(); popq();
    idle(1);

    // Fill, dropped push, drain.
    for (int i = 0; i < DEPTH; i++) push(16'hA000 + 16'(i));
    push(16'hBEEF);
    for (int i = 0; i < DEPTH + 1; i++) popq();

    // Full queue with simultaneous push/pop exercises pointer wrap.
    for (int i = 0; i < DEPTH; i++) push(16'hA000 + 16'(i));
    step(1'b1, 16'hC0DE, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) popq();

    // Empty queue push+pop.
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    popq();

    // Overflow then flush with a concurrent push.
    for (int i = 0; i < DEPTH + 1; i++) push(16'h0100 + 16'(i));
    popq(); popq();
    step(1'b1, 16'h7777, 1'b0, 1'b1);
    push(16'h1234);
    idle(1);

    // Flush together with a dropped push leaves ovf clear.
    for (int i = 0; i < DEPTH; i++) push(16'h0200 + 16'(i));
    step(1'b1, 16'hDEAD, 1'b0, 1'b1);
    idle(1);

    // Mid-stream asynchronous reset with three entries queued.
    push(16'h0A0A); push(16'h0B0B); push(16'h0C0C);
    do_reset();
    push(16'h0D0D);
    popq();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 60), 16'($urandom),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 4));
    end
    idle(2);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a small prefetch queue. It sits between the instruction-memory fetch path and CPU_EU. The fetch side pushes words into the queue, and the execution unit sees the oldest word on a held output until it pops it. Unlike a single-entry register, it decouples fetch from execute: it buffers up to DEPTH instructions and supports flush on branch, with occupancy reporting.

## Interface
- WIDTH, 16, instruction word width in bits (≥1)
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ld  in  1  push request; D_in is written when accepted
- D_in  in  WIDTH  instruction word to push
- pop  in  1  execution unit consumes current D_out
- flush  in  1  discard all queued entries (branch/jump taken)
- D_out  out  WIDTH  current instruction (head of queue)
- valid  out  1  D_out holds an unconsumed instruction
- full  out  1  count == DEPTH; push not accepted
- count  out  $clog2(DEPTH+1)  current occupancy
- ovf  out  1  sticky overflow flag; present only with IRQ_OVF_FLAG_EN

## Operation
- Storage is DEPTH×WIDTH entries with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Push is accepted when `ld && (!full || pop_eff)`. Here `pop_eff = pop && valid`.
- Pop is effective only when valid=1. A pop while empty is ignored, and count is unchanged.
- Simultaneous push and pop on a full queue: both take effect, and count stays DEPTH.
- Simultaneous push and pop on an empty queue: the push is accepted and the pop is ignored. count becomes 1.
- A push while full without pop is dropped, and the queue is unchanged.
- Priority: rst > flush > push/pop.
- flush sets count=0 and valid=0, and resets both pointers to 0. A push in the same cycle is discarded.
- D_out is registered. It is loaded with the new head entry whenever the head changes: on a push into an empty queue, or on an effective pop with count>1.
- When the queue drains (pop at count=1) or is flushed, D_out retains its last value and valid drops to 0.
- While valid=1 and no pop occurs, D_out is stable regardless of pushes.

## Timing
- Reset values: D_out=0, valid=0, full=0, count=0, ovf=0, pointers=0.
- Reset is asynchronous on assertion and takes effect immediately, including mid-operation. Stored entries are discarded.
- Latency from a push into an empty queue to valid=1 with D_out=D_in is one clock edge.
- An effective pop presents the next entry on D_out and updates count at the same edge.
- full and count are registered and reflect the post-edge occupancy.
- No combinational path exists from inputs to outputs.

## Configuration
- IRQ_OVF_FLAG_EN defined:
  - The ovf port exists.
  - ovf sets to 1 on the edge after any dropped push (ld=1, full=1, no effective pop).
  - ovf stays 1 until rst or flush.
  - flush and a dropped push in the same cycle leave ovf=0.
- IRQ_OVF_FLAG_EN undefined:
  - The ovf port and its logic are absent.
  - Dropped pushes are silent.
  - All other behaviour is identical.

## Structure
- Shared package ir_pkg:
  - IR_WIDTH_DEF = 16 and IR_DEPTH_DEF = 4.
  - Typedef `ir_word_t` (logic [IR_WIDTH_DEF-1:0]).
  - Reset constant IR_RST_WORD = '0.
- One sub-module, ir_ptr:
  - Parametrised wrap-around pointer with inc and clr inputs.
  - Asynchronous reset to 0.
  - Instantiated twice, as the read pointer and the write pointer.
- Storage array, count, full and D_out registers live in ir_queue.

## Test plan
- Reset then idle: all outputs 0. Assert rst mid-stream with count=3 → D_out=0, valid=0, count=0 immediately.
- Push 0x1111, then 0x2222 and 0x3333 on consecutive cycles; no pop:
  - valid=1 one edge after the first push.
  - D_out stays 0x1111 throughout.
  - count ends at 3.
  - Then pop three times → D_out 0x2222, 0x3333; valid=0 after the third pop; D_out holds 0x3333.
- Fill DEPTH=4 with 0xA000..0xA003, then push 0xBEEF:
  - full=1 and count=4.
  - 0xBEEF is dropped; draining yields only 0xA000..0xA003.
  - ovf=1 if IRQ_OVF_FLAG_EN is defined.
- Full queue, then ld=1 with D_in=0xC0DE and pop=1 in the same cycle:
  - count stays 4 and D_out=0xA001.
  - 0xC0DE emerges after 0xA003, confirming pointer wrap.
- Empty queue, ld=1 with D_in=0x5A5A and pop=1 → count=1, valid=1, D_out=0x5A5A.
- count=2, then flush=1 with ld=1 and D_in=0x7777:
  - count=0 and valid=0; ovf cleared.
  - The next push of 0x1234 appears on D_out one edge later.
